ps2_multipad_receiver: RTL and testbench

Parametrised successor to the single-pad PS/2 keyboard receiver. Decodes PS/2 keyboard frames into one or two NES gamepad button bytes, and adds:
- start/parity/stop frame checking
- clock glitch filtering and an idle timeout
- a selectable opposite-direction (SOCD) resolution mode
- change-only output updates

Sits between the board PS/2 pins and the controller-port buffer, which consumes data_o through a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 70 +++++++
 rtl/ps2_frame_rx.sv | 106 ++++++++++
 rtl/ps2_multipad_receiver.sv | 112 +++++++++++
 tb/tb_ps2_multipad_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan codes, button positions and key map for the PS/2 multipad receiver
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_KP0    = 8'h70;
    localparam logic [7:0] SC_KPDOT  = 8'h71;
    localparam logic [7:0] SC_KPPLUS = 8'h79;

    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    localparam int SOCD_NEUTRAL = 0;
    localparam int SOCD_LAST    = 1;

    typedef struct packed {
        logic       hit;
        logic       pad;
        logic [2:0] btn;
    } key_map_t;

    // Numpad directions and KP Enter move to pad1 when a second pad exists.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code, input int num_pads);
        key_map_t m;
        logic     alt;
        m   = '0;
        alt = (num_pads == 2);
        if (!ext) begin
            case (code)
                SC_Q:      m = '{hit: 1'b1, pad: 1'b0, btn: BTN_A};
                SC_W:      m = '{hit: 1'b1, pad: 1'b0, btn: BTN_B};
                SC_SPACE:  m = '{hit: 1'b1, pad: 1'b0, btn: BTN_SELECT};
                SC_ENTER:  m = '{hit: 1'b1, pad: 1'b0, btn: BTN_START};
                SC_UP:     m = '{hit: 1'b1, pad: alt, btn: BTN_UP};
                SC_DOWN:   m = '{hit: 1'b1, pad: alt, btn: BTN_DOWN};
                SC_LEFT:   m = '{hit: 1'b1, pad: alt, btn: BTN_LEFT};
                SC_RIGHT:  m = '{hit: 1'b1, pad: alt, btn: BTN_RIGHT};
                SC_KP0:    m = '{hit: alt, pad: 1'b1, btn: BTN_A};
                SC_KPDOT:  m = '{hit: alt, pad: 1'b1, btn: BTN_B};
                SC_KPPLUS: m = '{hit: alt, pad: 1'b1, btn: BTN_SELECT};
                default:   m = '0;
            endcase
        end else begin
            case (code)
                SC_UP:     m = '{hit: 1'b1, pad: 1'b0, btn: BTN_UP};
                SC_DOWN:   m = '{hit: 1'b1, pad: 1'b0, btn: BTN_DOWN};
                SC_LEFT:   m = '{hit: 1'b1, pad: 1'b0, btn: BTN_LEFT};
                SC_RIGHT:  m = '{hit: 1'b1, pad: 1'b0, btn: BTN_RIGHT};
                SC_ENTER:  m = '{hit: 1'b1, pad: alt, btn: BTN_START};
                default:   m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line synchroniser, clock filter, 11-bit framing check and idle timeout
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_q;
    logic [3:0]    flt_cnt_q;
    logic          edge_any, fall;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    sr_q;
    logic          start_ok_q, par_q;
    logic [TW-1:0] idle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_i;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    assign edge_any = (clk_s2 != filt_q) && (flt_cnt_q == 4'(FILTER_LEN - 1));
    assign fall     = edge_any && filt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_s2 == filt_q) begin
            flt_cnt_q <= '0;
        end else if (edge_any) begin
            filt_q    <= clk_s2;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            start_ok_q   <= 1'b0;
            par_q        <= 1'b0;
            idle_q       <= '0;
            byte_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            err_o        <= 1'b0;
            if (edge_any || bit_cnt_q == 4'd0)
                idle_q <= '0;
            else
                idle_q <= idle_q + 1'b1;
            if (fall) begin
                case (bit_cnt_q)
                    4'd0: begin
                        start_ok_q <= ~dat_s2;
                        bit_cnt_q  <= 4'd1;
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        sr_q      <= {dat_s2, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    4'd9: begin
                        par_q     <= dat_s2;
                        bit_cnt_q <= 4'd10;
                    end
                    default: begin
                        bit_cnt_q <= 4'd0;
                        if (start_ok_q && (^sr_q ^ par_q) && dat_s2)
                            byte_valid_o <= 1'b1;
                        else
                            err_o <= 1'b1;
                    end
                endcase
            end else if (bit_cnt_q != 4'd0 && idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_q <= 4'd0;
                idle_q    <= '0;
                err_o     <= 1'b1;
            end
        end
    end

    assign byte_o = sr_q;

endmodule

// File: rtl/ps2_multipad_receiver.sv
// rtl/ps2_multipad_receiver.sv - PS/2 keyboard to NES gamepad bytes with SOCD resolution and change-only updates
module ps2_multipad_receiver
    import ps2_pkg::*;
#(
    parameter int NUM_PADS       = 1,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SOCD_MODE      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_data_i,
    input  logic                  buffer_ready_i,
    output logic [8*NUM_PADS-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  frame_err_o
);

    logic [7:0]            rx_byte;
    logic                  rx_valid, rx_err;
    logic                  ext_q, brk_q, upd_q;
    logic [8*NUM_PADS-1:0] held_q, resolved;
    logic [NUM_PADS-1:0]   last_dn_q, last_rt_q;
    key_map_t              km;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .err_o       (rx_err)
    );

    assign frame_err_o = rx_err;
    assign km          = map_key(ext_q, rx_byte, NUM_PADS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            upd_q     <= 1'b0;
            held_q    <= '0;
            last_dn_q <= '0;
            last_rt_q <= '0;
        end else begin
            upd_q <= 1'b0;
            if (rx_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    upd_q <= 1'b1;
                    for (int p = 0; p < NUM_PADS; p++) begin
                        if (km.hit && km.pad == p[0]) begin
                            held_q[8*p + int'(km.btn)] <= ~brk_q;
                            // Only a make refreshes the last-pressed direction of a pair.
                            if (!brk_q) begin
                                if (km.btn == BTN_UP)    last_dn_q[p] <= 1'b0;
                                if (km.btn == BTN_DOWN)  last_dn_q[p] <= 1'b1;
                                if (km.btn == BTN_LEFT)  last_rt_q[p] <= 1'b0;
                                if (km.btn == BTN_RIGHT) last_rt_q[p] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        resolved = held_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (SOCD_MODE == SOCD_LAST) begin
                resolved[8*p+4] = held_q[8*p+4] & (~held_q[8*p+5] | ~last_dn_q[p]);
                resolved[8*p+5] = held_q[8*p+5] & (~held_q[8*p+4] |  last_dn_q[p]);
                resolved[8*p+6] = held_q[8*p+6] & (~held_q[8*p+7] | ~last_rt_q[p]);
                resolved[8*p+7] = held_q[8*p+7] & (~held_q[8*p+6] |  last_rt_q[p]);
            end else begin
                resolved[8*p+4] = held_q[8*p+4] & ~held_q[8*p+5];
                resolved[8*p+5] = held_q[8*p+5] & ~held_q[8*p+4];
                resolved[8*p+6] = held_q[8*p+6] & ~held_q[8*p+7];
                resolved[8*p+7] = held_q[8*p+7] & ~held_q[8*p+6];
            end
        end
    end

    // A changed vector always wins over a same-cycle acknowledge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else if (upd_q && resolved != data_o) begin
            data_o       <= resolved;
            data_valid_o <= 1'b1;
        end else if (data_valid_o && buffer_ready_i) begin
            data_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_multipad_receiver.sv
// tb/tb_ps2_multipad_receiver.sv - directed bench for ps2_multipad_receiver in three configurations
module tb_ps2_multipad_receiver;

    localparam int HALF = 20;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  data_a, data_b;
    logic [15:0] data_c;
    logic        valid_a, valid_b, valid_c;
    logic        err_a, err_b, err_c;
    int          errcnt_a, vrise_a, vrise_c;
    logic        pv_a, pv_c;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ps2_multipad_receiver #(.NUM_PADS(1), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .SOCD_MODE(0)) u_a (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .buffer_ready_i(ready), .data_o(data_a), .data_valid_o(valid_a), .frame_err_o(err_a));

    ps2_multipad_receiver #(.NUM_PADS(1), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .SOCD_MODE(1)) u_b (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .buffer_ready_i(ready), .data_o(data_b), .data_valid_o(valid_b), .frame_err_o(err_b));

    ps2_multipad_receiver #(.NUM_PADS(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .SOCD_MODE(0)) u_c (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .buffer_ready_i(ready), .data_o(data_c), .data_valid_o(valid_c), .frame_err_o(err_c));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt_a <= 0;
            vrise_a  <= 0;
            vrise_c  <= 0;
            pv_a     <= 1'b0;
            pv_c     <= 1'b0;
        end else begin
            if (err_a) errcnt_a <= errcnt_a + 1;
            if (valid_a && !pv_a) vrise_a <= vrise_a + 1;
            if (valid_c && !pv_c) vrise_c <= vrise_c + 1;
            pv_a <= valid_a;
            pv_c <= valid_c;
        end
    end

    task automatic do_reset();
        ready = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF / 2) @(negedge clk);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
    endtask

    task automatic ack();
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL reset_data_a: got %h want 00", data_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err_a: got %b want 0", err_a); end
        n_cmp++; if (data_c !== 16'h0000) begin n_bad++; $display("FAIL reset_data_c: got %h want 0000", data_c); end
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h15);
        n_cmp++; if (data_a !== 8'h01) begin n_bad++; $display("FAIL make_data: got %h want 01", data_a); end
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL make_valid: got %b want 1", valid_a); end
        ack();
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL ack_valid: got %b want 0", valid_a); end
        send(8'hF0); send(8'h15);
        n_cmp++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL break_data: got %h want 00", data_a); end
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL break_valid: got %b want 1", valid_a); end
    endtask

    task automatic test_socd();
        do_reset();
        send(8'hE0); send(8'h75);
        n_cmp++; if (data_a !== 8'h10) begin n_bad++; $display("FAIL socd0_up: got %h want 10", data_a); end
        n_cmp++; if (data_b !== 8'h10) begin n_bad++; $display("FAIL socd1_up: got %h want 10", data_b); end
        send(8'hE0); send(8'h72);
        n_cmp++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL socd0_both: got %h want 00", data_a); end
        n_cmp++; if (data_b !== 8'h20) begin n_bad++; $display("FAIL socd1_both: got %h want 20", data_b); end
        send(8'hE0); send(8'hF0); send(8'h72);
        n_cmp++; if (data_a !== 8'h10) begin n_bad++; $display("FAIL socd0_rel: got %h want 10", data_a); end
        n_cmp++; if (data_b !== 8'h10) begin n_bad++; $display("FAIL socd1_rel: got %h want 10", data_b); end
    endtask

    task automatic test_parity_err();
        do_reset();
        send_frame(8'h15, 1'b1, 11, -1);
        n_cmp++; if (errcnt_a !== 1) begin n_bad++; $display("FAIL parity_err_pulses: got %0d want 1", errcnt_a); end
        n_cmp++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL parity_data: got %h want 00", data_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL parity_valid: got %b want 0", valid_a); end
        send(8'h1D);
        n_cmp++; if (data_a !== 8'h02) begin n_bad++; $display("FAIL parity_next: got %h want 02", data_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_frame(8'h15, 1'b0, 5, -1);
        repeat (TO + 100) @(negedge clk);
        n_cmp++; if (errcnt_a !== 1) begin n_bad++; $display("FAIL timeout_err_pulses: got %0d want 1", errcnt_a); end
        send(8'h29);
        n_cmp++; if (data_a !== 8'h04) begin n_bad++; $display("FAIL timeout_next: got %h want 04", data_a); end
        n_cmp++; if (errcnt_a !== 1) begin n_bad++; $display("FAIL timeout_no_extra_err: got %0d want 1", errcnt_a); end
    endtask

    task automatic test_two_pads();
        do_reset();
        send(8'h5A);
        n_cmp++; if (data_c !== 16'h0008) begin n_bad++; $display("FAIL pads_enter: got %h want 0008", data_c); end
        send(8'hE0); send(8'h5A);
        n_cmp++; if (data_c !== 16'h0808) begin n_bad++; $display("FAIL pads_kpenter: got %h want 0808", data_c); end
        ack();
        send(8'h5A);
        n_cmp++; if (valid_c !== 1'b0) begin n_bad++; $display("FAIL pads_typematic_valid: got %b want 0", valid_c); end
        n_cmp++; if (vrise_c !== 1) begin n_bad++; $display("FAIL pads_valid_rises: got %0d want 1", vrise_c); end
        n_cmp++; if (data_c !== 16'h0808) begin n_bad++; $display("FAIL pads_typematic_data: got %h want 0808", data_c); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h15);
        send(8'h1D);
        n_cmp++; if (vrise_a !== 1) begin n_bad++; $display("FAIL b2b_valid_rises: got %0d want 1", vrise_a); end
        n_cmp++; if (data_a !== 8'h03) begin n_bad++; $display("FAIL b2b_data: got %h want 03", data_a); end
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", valid_a); end
    endtask

    task automatic test_glitch();
        do_reset();
        send_frame(8'h29, 1'b0, 11, 3);
        n_cmp++; if (data_a !== 8'h04) begin n_bad++; $display("FAIL glitch_data: got %h want 04", data_a); end
        n_cmp++; if (errcnt_a !== 0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", errcnt_a); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_socd();
        test_parity_err();
        test_timeout();
        test_two_pads();
        test_back_to_back();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
